add_round_key_stage: RTL and testbench
======================================

# add_round_key_stage

Registered AddRoundKey stage that sits directly downstream of the combinational MixColumns block in the AES encryption datapath. Each beat XORs a 128-bit round key onto either the MixColumns result or the bypass (pre-MixColumns) state, selected by round number. Results are held in a 2-entry output buffer with valid/ready handshakes on both sides, so the round loop can stall without losing data.

## Interface
- NR, 10: number of AES rounds; also the index of the final round, which has no MixColumns.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  upstream beat present.
- i_ready  out  1  stage can accept a beat.
- i_mixed  in  128  MixColumns output state.
- i_shifted  in  128  bypass state: ShiftRows output for round NR, plaintext for round 0.
- i_round  in  4  round index of this beat, 0..NR.
- i_key  in  128  round key for i_round.
- o_valid  out  1  buffered result available.
- o_ready  in  1  downstream accepts result.
- o_block  out  128  state after AddRoundKey.
- o_round  out  4  round index carried with o_block.
- o_last  out  1  o_round == NR (ciphertext beat).
- o_err  out  1  sticky: a beat with i_round > NR was received.
- o_done_cnt  out  16  count of o_last beats accepted downstream, wraps at 16'hFFFF -> 0.

## Operation
- Accept occurs when i_valid && i_ready. Emit occurs when o_valid && o_ready.
- Source select: use i_shifted when i_round == 0 or i_round == NR, otherwise use i_mixed.
- Result = source ^ i_key, computed bitwise over 128 bits with no reordering. Byte 0 is bits [127:120].
- Accepted beats with i_round > NR are dropped: nothing is written to the buffer, and o_err is set to 1. o_err clears only on reset.
- Buffer: 2-entry FIFO holding {block, round}.
  - Occupancy is 0, 1 or 2.
  - i_ready = (occupancy < 2). It comes from a register, not from o_ready.
  - o_valid = (occupancy > 0).
  - o_block and o_round always show the head entry.
- Occupancy update:
  - Accept only: +1.
  - Emit only: -1.
  - Accept and emit in the same cycle: unchanged. The head is popped and the new entry is written in order.
  - A dropped beat with emit in the same cycle: -1.
- o_done_cnt increments on every emit where o_last = 1.
- Reset, whether idle or mid-operation: occupancy = 0 and any buffered data is discarded. After reset, o_valid = 0, i_ready = 1, o_block = 0, o_round = 0, o_last = 0, o_err = 0, o_done_cnt = 0.

## Timing
- Latency: a beat accepted at edge N appears on o_valid/o_block after edge N, provided the buffer was empty.
- Throughput: 1 beat per cycle when o_ready is held high.
- With o_ready low: two beats are absorbed, then i_ready drops after the edge that fills entry 2.
- i_ready rises the cycle after the first emit from a full buffer. No combinational path exists from o_ready to i_ready.
- Outputs must not change while o_valid && !o_ready.
- Reset assertion takes effect immediately. Deassertion is synchronised externally, and the first accept can occur on the first edge after deassertion.

## Structure
- A shared package, aes_pkg, holds:
  - the constants AES_NR = 10, BLOCK_W = 128 and ROUND_W = 4;
  - the buffer-entry typedef {block[127:0], round[3:0]}.
- One natural sub-module, rka_fifo2: a generic 2-entry FIFO with occupancy counter and read/write pointers. The XOR/select logic, error flag and counter stay in the top level.

## Test plan
- Single beat through the middle round: i_round = 5, i_mixed = 128'h0, i_key = 128'h000102…0F -> o_block = 128'h000102…0F and o_round = 5, one cycle later, with o_last = 0.
- FIPS-197 round 0: i_shifted = 128'h00112233445566778899aabbccddeeff, i_key = 128'h000102030405060708090a0b0c0d0e0f, i_mixed = random -> o_block = 128'h00102030405060708090a0b0c0d0e0f0.
- Final round 10: i_shifted = 128'hFF…FF, i_key = 128'h0F…0F -> o_block = 128'hF0…F0, o_last = 1, and o_done_cnt increments 0 -> 1 on emit.
- Backpressure: hold o_ready = 0 and drive 3 valid beats -> i_ready falls after beat 2 and beat 3 is held upstream. Release o_ready -> the beats emerge in order 1, 2, 3 with no loss or duplication.
- Streaming with random o_ready and i_valid over 1000 beats: the output sequence equals a reference model, and occupancy never exceeds 2.
- Bad round and reset: i_round = 11 -> no output and o_err = 1. Then assert i_rst with 2 entries buffered -> o_valid = 0 immediately, o_err = 0, o_done_cnt = 0.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath constants and buffer-entry type
//
// Purpose: constants and types shared by the AddRoundKey stage and its FIFO.
// Contents:
//   AES_NR      number of AES-128 rounds (index of the final, MixColumns-free round)
//   BLOCK_W     state width in bits
//   ROUND_W     round index width in bits
//   rka_entry_t buffered result: {block, round}
package aes_pkg;

  localparam int AES_NR  = 10;
  localparam int BLOCK_W = 128;
  localparam int ROUND_W = 4;

  typedef struct packed {
    logic [BLOCK_W-1:0] block;
    logic [ROUND_W-1:0] round;
  } rka_entry_t;

endpackage

// File: rtl/rka_fifo2.sv
// rtl/rka_fifo2.sv - generic 2-entry FIFO with registered not-full flag
//
// Purpose: two-deep result buffer so the round loop can stall without loss.
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset, empties the FIFO and clears storage
//   i_push       write i_data (caller guarantees o_not_full)
//   i_data       entry to write
//   i_pop        remove head entry (caller guarantees o_not_empty)
//   o_data       head entry
//   o_not_full   registered: occupancy < 2
//   o_not_empty  occupancy > 0
module rka_fifo2 #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_not_full,
  output logic         o_not_empty
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         not_full_q;

  always_comb begin
    count_d = count_q;
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      not_full_q <= 1'b1;
    end else begin
      if (i_push) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (i_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q    <= count_d;
      // Registered from the next occupancy so downstream ready never reaches
      // upstream ready combinationally.
      not_full_q <= (count_d != 2'd2);
    end
  end

  assign o_data      = mem_q[rd_ptr_q];
  assign o_not_full  = not_full_q;
  assign o_not_empty = (count_q != 2'd0);

endmodule

// File: rtl/add_round_key_stage.sv
// rtl/add_round_key_stage.sv - registered AES AddRoundKey stage with 2-entry output buffer
//
// Purpose: XOR the round key onto the MixColumns result (middle rounds) or the
// bypass state (round 0 and round NR), buffer the result with its round index.
// Ports:
//   i_clk, i_rst      clock; asynchronous active-high reset
//   i_valid/i_ready   upstream handshake (i_ready is registered)
//   i_mixed           MixColumns output state
//   i_shifted         bypass state (plaintext for round 0, ShiftRows output for round NR)
//   i_round, i_key    round index of the beat and its round key
//   o_valid/o_ready   downstream handshake
//   o_block, o_round  head of the buffer
//   o_last            head is the final round
//   o_err             sticky: a beat with i_round > NR was accepted and dropped
//   o_done_cnt        number of final-round beats emitted, wrapping
module add_round_key_stage
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [BLOCK_W-1:0] i_mixed,
  input  logic [BLOCK_W-1:0] i_shifted,
  input  logic [ROUND_W-1:0] i_round,
  input  logic [BLOCK_W-1:0] i_key,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [BLOCK_W-1:0] o_block,
  output logic [ROUND_W-1:0] o_round,
  output logic               o_last,
  output logic               o_err,
  output logic [15:0]        o_done_cnt
);

  localparam logic [ROUND_W-1:0] NR_R = ROUND_W'(NR);

  logic               accept;
  logic               emit;
  logic               bad_round;
  logic               push;
  logic [BLOCK_W-1:0] source;
  rka_entry_t         wr_entry;
  rka_entry_t         head;
  logic               err_q;
  logic               err_d;
  logic [15:0]        done_q;
  logic [15:0]        done_d;

  assign accept    = i_valid && i_ready;
  assign emit      = o_valid && o_ready;
  assign bad_round = (i_round > NR_R);
  assign push      = accept && !bad_round;

  // Round 0 whitens the plaintext and the final round skips MixColumns, so
  // both take the bypass state.
  assign source = ((i_round == '0) || (i_round == NR_R)) ? i_shifted : i_mixed;

  always_comb begin
    wr_entry       = '0;
    wr_entry.block = source ^ i_key;
    wr_entry.round = i_round;
  end

  rka_fifo2 #(
    .W($bits(rka_entry_t))
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (push),
    .i_data     (wr_entry),
    .i_pop      (emit),
    .o_data     (head),
    .o_not_full (i_ready),
    .o_not_empty(o_valid)
  );

  assign o_block = head.block;
  assign o_round = head.round;
  assign o_last  = (head.round == NR_R);

  always_comb begin
    err_d  = err_q | (accept && bad_round);
    done_d = done_q;
    if (emit && o_last) begin
      done_d = done_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q  <= 1'b0;
      done_q <= 16'd0;
    end else begin
      err_q  <= err_d;
      done_q <= done_d;
    end
  end

  assign o_err      = err_q;
  assign o_done_cnt = done_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// tb/tb_add_round_key_stage.sv - directed and streaming bench for add_round_key_stage
module tb_add_round_key_stage;

  logic         i_clk;
  logic         i_rst;
  logic         i_valid;
  logic         i_ready;
  logic [127:0] i_mixed;
  logic [127:0] i_shifted;
  logic [3:0]   i_round;
  logic [127:0] i_key;
  logic         o_valid;
  logic         o_ready;
  logic [127:0] o_block;
  logic [3:0]   o_round;
  logic         o_last;
  logic         o_err;
  logic [15:0]  o_done_cnt;

  int checks = 0;
  int errors = 0;

  add_round_key_stage dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_mixed   (i_mixed),
    .i_shifted (i_shifted),
    .i_round   (i_round),
    .i_key     (i_key),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_block   (o_block),
    .o_round   (o_round),
    .o_last    (o_last),
    .o_err     (o_err),
    .o_done_cnt(o_done_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] q_blk[$];
  logic [3:0]   q_rnd[$];
  logic [127:0] exp_blk;
  logic [15:0]  exp_done;
  logic         acc;
  logic         emt;
  int           emitted;
  int           cyc;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
    i_mixed = '0; i_shifted = '0; i_round = '0; i_key = '0;
    exp_done = 16'd0;
    @(negedge i_clk);
    @(negedge i_clk);

    // Reset state
    chk("rst_o_valid", 128'(o_valid), 128'(1'b0));
    chk("rst_i_ready", 128'(i_ready), 128'(1'b1));
    chk("rst_o_block", o_block, 128'h0);
    chk("rst_o_round", 128'(o_round), 128'(4'd0));
    chk("rst_o_last", 128'(o_last), 128'(1'b0));
    chk("rst_o_err", 128'(o_err), 128'(1'b0));
    chk("rst_done", 128'(o_done_cnt), 128'(16'd0));
    i_rst = 1'b0;

    // Middle round 5: mixed path, key passes through untouched
    i_valid = 1'b1; i_round = 4'd5; i_mixed = 128'h0; i_shifted = rnd128();
    i_key = 128'h000102030405060708090a0b0c0d0e0f;
    tick();
    i_valid = 1'b0;
    chk("r5_o_valid", 128'(o_valid), 128'(1'b1));
    chk("r5_o_block", o_block, 128'h000102030405060708090a0b0c0d0e0f);
    chk("r5_o_round", 128'(o_round), 128'(4'd5));
    chk("r5_o_last", 128'(o_last), 128'(1'b0));
    tick();
    chk("r5_hold_block", o_block, 128'h000102030405060708090a0b0c0d0e0f);
    o_ready = 1'b1;
    tick();
    chk("r5_drained", 128'(o_valid), 128'(1'b0));

    // FIPS-197 round 0 whitening: bypass path, mixed is noise
    i_valid = 1'b1; i_round = 4'd0; i_mixed = rnd128();
    i_shifted = 128'h00112233445566778899aabbccddeeff;
    i_key = 128'h000102030405060708090a0b0c0d0e0f;
    tick();
    i_valid = 1'b0;
    chk("r0_o_valid", 128'(o_valid), 128'(1'b1));
    chk("r0_o_block", o_block, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("r0_o_round", 128'(o_round), 128'(4'd0));
    tick();
    chk("r0_drained", 128'(o_valid), 128'(1'b0));

    // Final round 10: bypass path, o_last and done counter
    o_ready = 1'b0;
    i_valid = 1'b1; i_round = 4'd10; i_mixed = rnd128();
    i_shifted = {16{8'hFF}}; i_key = {16{8'h0F}};
    tick();
    i_valid = 1'b0;
    chk("r10_o_block", o_block, {16{8'hF0}});
    chk("r10_o_last", 128'(o_last), 128'(1'b1));
    chk("r10_done_before", 128'(o_done_cnt), 128'(16'd0));
    o_ready = 1'b1;
    tick();
    exp_done = 16'd1;
    chk("r10_done_after", 128'(o_done_cnt), 128'(16'd1));
    chk("r10_drained", 128'(o_valid), 128'(1'b0));

    // Backpressure: three beats, o_ready low
    o_ready = 1'b0; i_key = '0;
    i_valid = 1'b1; i_round = 4'd1; i_mixed = {16{8'h11}};
    chk("bp_ready0", 128'(i_ready), 128'(1'b1));
    tick();
    chk("bp_ready1", 128'(i_ready), 128'(1'b1));
    i_round = 4'd2; i_mixed = {16{8'h22}};
    tick();
    chk("bp_ready2", 128'(i_ready), 128'(1'b0));
    chk("bp_head1", o_block, {16{8'h11}});
    i_round = 4'd3; i_mixed = {16{8'h33}};
    tick();
    chk("bp_held_ready", 128'(i_ready), 128'(1'b0));
    chk("bp_held_round", 128'(o_round), 128'(4'd1));
    o_ready = 1'b1;
    chk("bp_ready_not_comb", 128'(i_ready), 128'(1'b0));
    tick();
    chk("bp_out2_round", 128'(o_round), 128'(4'd2));
    chk("bp_out2_block", o_block, {16{8'h22}});
    chk("bp_ready_back", 128'(i_ready), 128'(1'b1));
    tick();
    i_valid = 1'b0;
    chk("bp_out3_round", 128'(o_round), 128'(4'd3));
    chk("bp_out3_block", o_block, {16{8'h33}});
    tick();
    chk("bp_empty", 128'(o_valid), 128'(1'b0));

    // Streaming against a reference queue
    emitted = 0; cyc = 0;
    while (emitted < 1000 && cyc < 20000) begin
      chk("st_o_valid", 128'(o_valid), 128'(q_blk.size() > 0));
      chk("st_i_ready", 128'(i_ready), 128'(q_blk.size() < 2));
      if (q_blk.size() > 0) begin
        chk("st_o_block", o_block, q_blk[0]);
        chk("st_o_round", 128'(o_round), 128'(q_rnd[0]));
        chk("st_o_last", 128'(o_last), 128'(q_rnd[0] == 4'd10));
      end
      i_valid = ($urandom_range(3) != 0);
      o_ready = $urandom_range(1)[0];
      i_round = 4'($urandom_range(10));
      i_mixed = rnd128(); i_shifted = rnd128(); i_key = rnd128();
      exp_blk = ((i_round == 4'd0) || (i_round == 4'd10)) ? (i_shifted ^ i_key) : (i_mixed ^ i_key);
      acc = i_valid && (q_blk.size() < 2);
      emt = o_ready && (q_blk.size() > 0);
      tick();
      if (emt) begin
        if (q_rnd[0] == 4'd10) exp_done = exp_done + 16'd1;
        void'(q_blk.pop_front());
        void'(q_rnd.pop_front());
        emitted++;
      end
      if (acc) begin
        q_blk.push_back(exp_blk);
        q_rnd.push_back(i_round);
      end
      chk("st_occupancy", 128'(q_blk.size() <= 2), 128'(1'b1));
      cyc++;
    end
    chk("st_beats_emitted", 128'(emitted), 128'(1000));
    chk("st_done_cnt", 128'(o_done_cnt), 128'(exp_done));
    i_valid = 1'b0; o_ready = 1'b1;
    tick();
    tick();
    chk("st_drained", 128'(o_valid), 128'(1'b0));

    // Bad round is dropped and flagged
    i_valid = 1'b1; i_round = 4'd11; i_mixed = rnd128(); i_shifted = rnd128();
    tick();
    i_valid = 1'b0;
    chk("bad_no_output", 128'(o_valid), 128'(1'b0));
    chk("bad_o_err", 128'(o_err), 128'(1'b1));
    tick();
    chk("bad_err_sticky", 128'(o_err), 128'(1'b1));

    // Reset mid-operation with two entries buffered
    o_ready = 1'b0; i_valid = 1'b1; i_round = 4'd10;
    tick();
    tick();
    i_valid = 1'b0;
    chk("pre_rst_full", 128'(i_ready), 128'(1'b0));
    chk("pre_rst_valid", 128'(o_valid), 128'(1'b1));
    i_rst = 1'b1;
    #1;
    chk("async_rst_o_valid", 128'(o_valid), 128'(1'b0));
    chk("async_rst_i_ready", 128'(i_ready), 128'(1'b1));
    chk("async_rst_o_err", 128'(o_err), 128'(1'b0));
    chk("async_rst_done", 128'(o_done_cnt), 128'(16'd0));
    chk("async_rst_block", o_block, 128'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();
    chk("post_rst_o_valid", 128'(o_valid), 128'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
